// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared definitions for the instruction fetch unit:
//               default widths, fetch state encoding, per-cycle fetch
//               action encoding and the program-counter reset value.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int FETCH_ADDR_W = 16;
  localparam int FETCH_INST_W = 10;
  localparam int FETCH_OFF_W  = 8;

  // Execution always begins at address zero.
  localparam int C_RESET_PC = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  // What the fetch stage does this cycle while running, highest priority first.
  typedef enum logic [2:0] {
    ACT_HALT   = 3'd0,
    ACT_JUMP   = 3'd1,
    ACT_BRANCH = 3'd2,
    ACT_STALL  = 3'd3,
    ACT_FETCH  = 3'd4
  } fetch_act_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_pc_next.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_next
// Description : Combinational next-PC selection for the fetch unit.
//               Priority: halt > jump > branch > stall > sequential.
//               Redirects only act when the fetch register holds a live word.
//               Branch target is inst_pc + sign-extended offset, modulo
//               2^ADDR_W; sequential increment wraps likewise.
// Ports       : pc, inst_pc, inst_valid      - current fetch state
//               halt, stall                  - decoder control
//               jump_en, jump_target         - absolute redirect
//               branch_en, branch_off        - relative redirect
//               pc_next, act                 - selected PC and action
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int OFF_W  = FETCH_OFF_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_valid,
  input  logic              halt,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_en,
  input  logic [OFF_W-1:0]  branch_off,
  output logic [ADDR_W-1:0] pc_next,
  output fetch_act_t        act
);

  logic [ADDR_W-1:0] w_off_sext;

  assign w_off_sext = {{(ADDR_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};

  always_comb begin
    act     = ACT_FETCH;
    pc_next = pc + ADDR_W'(1);
    if (halt) begin
      act     = ACT_HALT;
      pc_next = pc;
    end else if (jump_en && inst_valid) begin
      act     = ACT_JUMP;
      pc_next = jump_target;
    end else if (branch_en && inst_valid) begin
      act     = ACT_BRANCH;
      pc_next = inst_pc + w_off_sext;
    end else if (stall) begin
      act     = ACT_STALL;
      pc_next = pc;
    end
  end

endmodule : fetch_pc_next
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch unit. Owns the PC, addresses the
//               instruction ROM and registers the returned word into a
//               one-stage fetch register for the decoder.
// Ports       : CLK, reset (sync, active-high), start
//               InstAddress -> ROM, InstIn <- ROM
//               inst_out / inst_pc / inst_valid - fetch register
//               stall, jump_en/jump_target, branch_en/branch_off, halt
//               done (HALTED), inst_count (retired instructions)
// Option      : INST_FETCH_COUNT_EN - when defined, inst_count counts
//               retired instructions (saturating); otherwise tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int INST_W = FETCH_INST_W,
  parameter int OFF_W  = FETCH_OFF_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] InstAddress,
  input  logic [INST_W-1:0] InstIn,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_en,
  input  logic [OFF_W-1:0]  branch_off,
  input  logic              halt,
  output logic              done,
  output logic [ADDR_W-1:0] inst_count
);

  localparam logic [ADDR_W-1:0] C_PC0 = ADDR_W'(C_RESET_PC);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_out_q, inst_out_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;

  logic [ADDR_W-1:0] w_pc_next;
  fetch_act_t        w_act;

  fetch_pc_next #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_pc_next (
    .pc          (pc_q),
    .inst_pc     (inst_pc_q),
    .inst_valid  (inst_valid_q),
    .halt        (halt),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .branch_en   (branch_en),
    .branch_off  (branch_off),
    .pc_next     (w_pc_next),
    .act         (w_act)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    case (state_q)
      ST_IDLE: begin
        pc_d = C_PC0;
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        pc_d = w_pc_next;
        case (w_act)
          ACT_HALT: begin
            state_d      = ST_HALTED;
            inst_valid_d = 1'b0;
          end
          // A redirect squashes the wrong-path word already in flight.
          ACT_JUMP, ACT_BRANCH: begin
            inst_valid_d = 1'b0;
          end
          ACT_STALL: begin
          end
          default: begin
            inst_out_d   = InstIn;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
          end
        endcase
      end
      ST_HALTED: begin
        if (start) begin
          state_d      = ST_RUN;
          pc_d         = C_PC0;
          inst_out_d   = '0;
          inst_pc_d    = '0;
          inst_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= C_PC0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

`ifdef INST_FETCH_COUNT_EN
  logic [ADDR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start && (state_q != ST_RUN)) begin
      count_d = '0;
    end else if ((state_q == ST_RUN) && inst_valid_q && !stall && !halt
                 && (count_q != {ADDR_W{1'b1}})) begin
      count_d = count_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign inst_count = count_q;
`else
  assign inst_count = '0;
`endif

  assign InstAddress = pc_q;
  assign inst_out    = inst_out_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = inst_valid_q;
  assign done        = (state_q == ST_HALTED);

endmodule : inst_fetch
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch. A behavioural model of
//               the fetch rules is compared against every output each cycle;
//               directed scenarios add hand-computed literal expectations.
//               Honours INST_FETCH_COUNT_EN for the inst_count expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] InstAddress;
  logic [9:0]  InstIn;
  logic [9:0]  inst_out;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        stall = 1'b0;
  logic        jump_en = 1'b0;
  logic [15:0] jump_target = '0;
  logic        branch_en = 1'b0;
  logic [7:0]  branch_off = '0;
  logic        halt = 1'b0;
  logic        done;
  logic [15:0] inst_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  function automatic logic [9:0] rom(input logic [15:0] a);
    return a[9:0] ^ 10'h2A5;
  endfunction

  assign InstIn = rom(InstAddress);

  inst_fetch dut (
    .CLK         (CLK),
    .reset       (reset),
    .start       (start),
    .InstAddress (InstAddress),
    .InstIn      (InstIn),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .branch_en   (branch_en),
    .branch_off  (branch_off),
    .halt        (halt),
    .done        (done),
    .inst_count  (inst_count)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = idle, 1 = running, 2 = halted
  int          m_mode  = 0;
  logic [15:0] m_pc    = '0;
  logic [9:0]  m_out   = '0;
  logic [15:0] m_ipc   = '0;
  bit          m_valid = 1'b0;
  logic [15:0] m_cnt   = '0;

  always @(posedge CLK) begin
    if (reset) begin
      m_mode = 0; m_pc = 0; m_out = 0; m_ipc = 0; m_valid = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (start) begin
        m_mode = 1; m_cnt = 0;
      end
    end else if (m_mode == 1) begin
`ifdef INST_FETCH_COUNT_EN
      if (m_valid && !stall && !halt && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
      if (halt) begin
        m_mode = 2; m_valid = 0;
      end else if (jump_en && m_valid) begin
        m_pc = jump_target; m_valid = 0;
      end else if (branch_en && m_valid) begin
        m_pc = 16'(int'(m_ipc) + int'($signed(branch_off))); m_valid = 0;
      end else if (!stall) begin
        m_out = rom(m_pc); m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 16'd1;
      end
    end else begin
      if (start) begin
        m_mode = 1; m_pc = 0; m_out = 0; m_ipc = 0; m_valid = 0; m_cnt = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("InstAddress", 32'(InstAddress), 32'(m_pc));
      check("inst_out",    32'(inst_out),    32'(m_out));
      check("inst_pc",     32'(inst_pc),     32'(m_ipc));
      check("inst_valid",  32'(inst_valid),  32'(m_valid));
      check("done",        32'(done),        32'(m_mode == 2));
      check("inst_count",  32'(inst_count),  32'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  logic [15:0] exp_cnt10;

  initial begin
`ifdef INST_FETCH_COUNT_EN
    exp_cnt10 = 16'd10;
`else
    exp_cnt10 = 16'd0;
`endif
    step(2);
    chk_en = 1'b1;
    reset  = 1'b0;
    check("rst_addr",  32'(InstAddress), 32'h0);
    check("rst_valid", 32'(inst_valid),  32'h0);
    check("rst_done",  32'(done),        32'h0);

    // Sequential fetch from address 0
    start = 1'b1; step(1); start = 1'b0;
    check("start_bubble_valid", 32'(inst_valid), 32'h0);
    step(1);
    check("first_pc",    32'(inst_pc),    32'h0);
    check("first_valid", 32'(inst_valid), 32'h1);
    check("first_word",  32'(inst_out),   32'h2A5);
    step(3);
    check("seq_pc3", 32'(inst_pc), 32'h3);

    // Jump at inst_pc=3
    jump_en = 1'b1; jump_target = 16'h0010; step(1); jump_en = 1'b0;
    check("jump_bubble", 32'(inst_valid), 32'h0);
    check("jump_addr",   32'(InstAddress), 32'h10);
    step(1);
    check("jump_tgt_pc", 32'(inst_pc), 32'h10);

    // Return to 0, then branch -4 at inst_pc=2
    jump_en = 1'b1; jump_target = 16'h0000; step(1); jump_en = 1'b0;
    step(3);
    check("pre_branch_pc", 32'(inst_pc), 32'h2);
    branch_en = 1'b1; branch_off = 8'hFC; step(1); branch_en = 1'b0;
    check("branch_addr", 32'(InstAddress), 32'hFFFE);
    step(1);
    check("branch_tgt_pc", 32'(inst_pc), 32'hFFFE);
    step(1);
    check("wrap_ffff", 32'(inst_pc), 32'hFFFF);
    step(1);
    check("wrap_0000", 32'(inst_pc), 32'h0);

    // Stall at inst_pc=5
    step(5);
    check("pre_stall_pc", 32'(inst_pc), 32'h5);
    stall = 1'b1; step(3);
    check("stall_pc",   32'(inst_pc),     32'h5);
    check("stall_addr", 32'(InstAddress), 32'h6);
    stall = 1'b0; step(1);
    check("resume_pc", 32'(inst_pc), 32'h6);
    stall = 1'b1; jump_en = 1'b1; jump_target = 16'h0040; step(1);
    stall = 1'b0; jump_en = 1'b0;
    check("stall_jump_addr", 32'(InstAddress), 32'h40);
    step(1);
    check("stall_jump_pc", 32'(inst_pc), 32'h40);

    // Start while running is ignored
    start = 1'b1; step(1); start = 1'b0;
    check("start_in_run_pc", 32'(inst_pc), 32'h41);

    // Halt with simultaneous jump at inst_pc=7
    jump_en = 1'b1; jump_target = 16'h0007; step(1); jump_en = 1'b0;
    step(1);
    check("pre_halt_pc", 32'(inst_pc), 32'h7);
    halt = 1'b1; jump_en = 1'b1; jump_target = 16'h0100; step(1);
    halt = 1'b0; jump_en = 1'b0;
    check("halt_done",  32'(done),        32'h1);
    check("halt_valid", 32'(inst_valid),  32'h0);
    check("halt_addr",  32'(InstAddress), 32'h8);
    step(2);
    start = 1'b1; step(1); start = 1'b0;
    check("restart_done", 32'(done), 32'h0);
    step(1);
    check("restart_pc", 32'(inst_pc), 32'h0);

    // Counter: 10 unstalled fetches then halt
    reset = 1'b1; step(1); reset = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    step(11);
    halt = 1'b1; step(1); halt = 1'b0;
    check("count10", 32'(inst_count), 32'(exp_cnt10));
    start = 1'b1; step(1); start = 1'b0;
    check("count_cleared", 32'(inst_count), 32'h0);

    // Reset mid-run with other inputs active
    step(4);
    reset = 1'b1; jump_en = 1'b1; start = 1'b1; stall = 1'b1; step(1);
    reset = 1'b0; jump_en = 1'b0; start = 1'b0; stall = 1'b0;
    check("midrst_addr",  32'(InstAddress), 32'h0);
    check("midrst_out",   32'(inst_out),    32'h0);
    check("midrst_valid", 32'(inst_valid),  32'h0);
    check("midrst_count", 32'(inst_count),  32'h0);

    // Mixed-pattern burst checked by the model only
    for (int i = 0; i < 400; i++) begin
      start       = ($urandom % 15) == 0;
      halt        = ($urandom % 30) == 0;
      stall       = ($urandom % 5) == 0;
      jump_en     = ($urandom % 9) == 0;
      jump_target = 16'($urandom);
      branch_en   = ($urandom % 7) == 0;
      branch_off  = 8'($urandom);
      reset       = ($urandom % 120) == 0;
      step(1);
    end
    reset = 1'b0; start = 1'b0; halt = 1'b0; stall = 1'b0;
    jump_en = 1'b0; branch_en = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_inst_fetch
`default_nettype wire

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the single-cycle CPU: owns the program counter, drives the address side of the instruction ROM, and registers the returned 10-bit word into a one-stage fetch register for the decoder. It sits between InstROM and the decode/control logic. Redirects (jump/branch), stall and halt come back from the decoder.

## Interface
Parameters:
- ADDR_W, 16, width of PC and InstAddress
- INST_W, 10, instruction word width
- OFF_W, 8, signed branch offset width

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle pulse, begins execution at address 0
- InstAddress  output  ADDR_W  address to ROM, equals PC register (combinational from register)
- InstIn  input  INST_W  word returned combinationally by ROM
- inst_out  output  INST_W  registered instruction
- inst_pc  output  ADDR_W  address inst_out was fetched from
- inst_valid  output  1  inst_out is a live instruction
- stall  input  1  decoder cannot accept; hold all fetch state
- jump_en  input  1  absolute redirect for current inst_out
- jump_target  input  ADDR_W  absolute target
- branch_en  input  1  taken relative branch for current inst_out
- branch_off  input  OFF_W  signed offset, relative to inst_pc
- halt  input  1  stop fetching
- done  output  1  high in HALTED
- inst_count  output  ADDR_W  retired-instruction counter (see Configuration)

## Operation
- States: IDLE, RUN, HALTED. Reset -> IDLE.
- IDLE: PC=0, inst_valid=0. start -> RUN.
- RUN, per cycle, priority high to low:
  - halt: -> HALTED, inst_valid<=0, PC held.
  - jump_en & inst_valid: PC<=jump_target, inst_valid<=0 (squash wrong-path word).
  - branch_en & inst_valid: PC<=inst_pc+sext(branch_off) mod 2^ADDR_W, inst_valid<=0.
  - stall: PC, inst_out, inst_pc, inst_valid held.
  - else: inst_out<=InstIn, inst_pc<=PC, inst_valid<=1, PC<=PC+1.
- jump_en/branch_en with inst_valid=0 are ignored. Both asserted: jump wins. Redirect beats stall.
- PC increment wraps 0xFFFF -> 0x0000; branch arithmetic modulo 2^ADDR_W, no error.
- HALTED: done=1, outputs frozen except inst_valid=0; start -> RUN with PC=0, fetch register cleared.
- start while RUN: ignored.
- Reset mid-operation: all state to reset values on that edge regardless of other inputs.

## Timing
- Reset values: InstAddress=0, inst_out=0, inst_pc=0, inst_valid=0, done=0, inst_count=0.
- start at edge N -> RUN after N; first word at address 0 appears on inst_out, inst_valid=1 after edge N+1.
- Fetch latency: 1 cycle from InstAddress to inst_out.
- Redirect penalty: 1 bubble cycle (inst_valid=0), target word valid the following cycle.
- halt at edge N: done=1 after N.
- No combinational path from any input to any output except InstAddress (from PC register only).

## Configuration
- INST_FETCH_COUNT_EN defined: inst_count increments on each cycle where inst_valid=1 and stall=0 and no halt; saturates at 0xFFFF; cleared by reset and by start.
- Not defined: counter logic absent, inst_count tied to 0.

## Structure
- Shared package fetch_pkg: ADDR_W/INST_W/OFF_W defaults, state enum (IDLE, RUN, HALTED), reset-PC constant 0.
- One sub-module: fetch_pc_next (combinational next-PC select: halt/jump/branch/stall/increment, sign extension, wrap).

## Test plan
- Reset then start, stall=0, ROM word = address low bits: inst_pc sequence 0,1,2,3 with inst_valid=1 from second cycle after start.
- jump_en with jump_target=0x0010 while inst_pc=3: one cycle inst_valid=0, next inst_pc=0x0010.
- branch_en, branch_off=-4 (0xFC) at inst_pc=2: target 0xFFFE (wrap), then 0xFFFF, 0x0000.
- stall held 3 cycles at inst_pc=5: inst_out/inst_pc/InstAddress unchanged; resumes with inst_pc=6; jump_en during stall still redirects.
- halt at inst_pc=7 with jump_en simultaneously: done=1, inst_valid=0, PC not redirected; start -> inst_pc=0.
- With INST_FETCH_COUNT_EN: 10 unstalled fetches then halt -> inst_count=10; reset mid-run -> all outputs 0 next cycle.
